// File: rtl/jkff_pkg.sv
// Shared command encodings and next-state helper for the JK flip-flop bank.
package jkff_pkg;

  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_CLR    = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  typedef enum logic [1:0] {
    CMD_HOLD   = JK_HOLD,
    CMD_CLR    = JK_CLR,
    CMD_SET    = JK_SET,
    CMD_TOGGLE = JK_TOGGLE
  } jk_cmd_t;

  // Next value of one bit for a {j,k} command.
  function automatic logic jk_next(input jk_cmd_t cmd, input logic cur);
    logic nxt;
    nxt = cur;
    case (cmd)
      CMD_HOLD:   nxt = cur;
      CMD_CLR:    nxt = 1'b0;
      CMD_SET:    nxt = 1'b1;
      CMD_TOGGLE: nxt = ~cur;
      default:    nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/jkff_bit.sv
// Single JK storage cell with asynchronous active-low reset to rst_val.
module jkff_bit
  import jkff_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  input  logic rst_val,
  output logic q
);

  jk_cmd_t cmd;

  assign cmd = jk_cmd_t'({j, k});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= rst_val;
    end else begin
      q <= jk_next(cmd, q);
    end
  end

endmodule

// File: rtl/jkff.sv
// Bank of WIDTH independent JK flip-flops; qnot is the combinational complement of q.
module jkff
  import jkff_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qnot
);

  localparam logic [WIDTH-1:0] RST = RESET_VAL;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jkff_bit u_bit (
      .clk     (clk),
      .reset   (reset),
      .j       (j[i]),
      .k       (k[i]),
      .rst_val (RST[i]),
      .q       (q[i])
    );
  end

  assign qnot = ~q;

endmodule

// File: tb/tb_jkff.sv
// Scoreboard bench for jkff: a 1-bit and a 4-bit (RESET_VAL=1010) instance driven in parallel.
module tb_jkff;

  logic       clk;
  logic       rst;
  logic       j1, k1;
  logic       q1, qn1;
  logic [3:0] j4, k4;
  logic [3:0] q4, qn4;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      nm;
    logic       e1;
    logic [3:0] e4;
  } exp_t;

  exp_t sb[$];

  jkff #(.WIDTH(1)) u1 (
    .clk(clk), .reset(rst), .j(j1), .k(k1), .q(q1), .qnot(qn1)
  );

  jkff #(.WIDTH(4), .RESET_VAL(4'b1010)) u4 (
    .clk(clk), .reset(rst), .j(j4), .k(k4), .q(q4), .qnot(qn4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expected entry is consumed per falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks += 4;
      if (q1 !== e.e1) begin
        errors++;
        $display("FAIL %s q1 got %b want %b", e.nm, q1, e.e1);
      end
      if (qn1 !== ~e.e1) begin
        errors++;
        $display("FAIL %s qnot1 got %b want %b", e.nm, qn1, ~e.e1);
      end
      if (q4 !== e.e4) begin
        errors++;
        $display("FAIL %s q4 got %b want %b", e.nm, q4, e.e4);
      end
      if (qn4 !== ~e.e4) begin
        errors++;
        $display("FAIL %s qnot4 got %b want %b", e.nm, qn4, ~e.e4);
      end
    end
  end

  // Drive inputs after a falling edge; the result is checked at the following falling edge.
  task automatic step(input logic r, input logic jv1, input logic kv1,
                      input logic [3:0] jv4, input logic [3:0] kv4,
                      input logic e1, input logic [3:0] e4, input string nm);
    exp_t e;
    @(negedge clk);
    #1;
    rst = r;
    j1  = jv1;
    k1  = kv1;
    j4  = jv4;
    k4  = kv4;
    e.nm = nm;
    e.e1 = e1;
    e.e4 = e4;
    sb.push_back(e);
  endtask

  initial begin
    rst = 1'b0;
    j1  = 1'b1;
    k1  = 1'b1;
    j4  = 4'hF;
    k4  = 4'hF;

    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 4'hF, 4'hF, 1'b0, 4'b1010, "in_reset");

    step(1'b1, 1'b1, 1'b1, 4'b0011, 4'b0101, 1'b1, 4'b1011, "release_mixed");
    step(1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0, 4'b1011, "toggle_a");
    step(1'b1, 1'b1, 1'b1, 4'hF, 4'hF, 1'b1, 4'b0100, "toggle_b");
    step(1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0, 4'b0100, "toggle_c");

    step(1'b1, 1'b1, 1'b0, 4'h0, 4'hF, 1'b1, 4'b0000, "set");
    step(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 4'b0000, "hold_hi");
    step(1'b1, 1'b0, 1'b1, 4'hF, 4'h0, 1'b0, 4'b1111, "clear");
    step(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'b1111, "hold_lo");

    step(1'b1, 1'b1, 1'b0, 4'b0101, 4'b1010, 1'b1, 4'b0101, "set_again");
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 4'b0101, "hold_10");

    // Edge applies the set, then reset lands between edges and must win before the check.
    step(1'b1, 1'b1, 1'b0, 4'hF, 4'h0, 1'b0, 4'b1010, "async_reset");
    @(posedge clk);
    #2;
    rst = 1'b0;

    step(1'b0, 1'b1, 1'b1, 4'hF, 4'hF, 1'b0, 4'b1010, "reset_held");
    step(1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 4'b1010, "release_set");
    step(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 4'b1010, "post_hold");

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain pending %0d want 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
